axi_arp_tx: RTL and testbench
=============================

// Module: axi_arp_tx
// PURPOSE
// - Transmit end of the ARP req/ack interface: on arp_tx_req, latches the ARP fields, acks, and
//   serialises one Ethernet II + ARP frame onto an 8-bit AXI4-Stream master.
// - Sits between the ARP state machine and the Ethernet TX arbiter/MAC. No FCS (MAC appends it).
// PARAMETERS
// - PAD_TO_MIN   1  1: pad frame with 0x00 to 60 bytes; 0: emit 42-byte frame unpadded
// - ACK_ON_LAST  0  0: ack at field capture; 1: ack after the tlast beat is accepted
// PORTS
// - clk              in   1   clock
// - aresetn          in   1   reset, synchronous, active-low
// - arp_tx_req       in   1   level request; held until ack seen
// - arp_tx_ack       out  1   single-cycle acknowledge pulse
// - arp_tx_opcode    in   16  ARP_OPER_REQUEST(1) / ARP_OPER_REPLY(2); else dropped
// - arp_tx_src_mac   in   48  sender MAC (Ethernet SA and ARP SHA)
// - arp_tx_src_ip    in   32  sender IP (ARP SPA)
// - arp_tx_dst_mac   in   48  Ethernet DA; also ARP THA for REPLY
// - arp_tx_dst_ip    in   32  ARP TPA
// - m_axis_tdata     out  8   frame byte, network order (MSB of each field first)
// - m_axis_tvalid    out  1   AXI-S valid
// - m_axis_tready    in   1   AXI-S ready
// - m_axis_tlast     out  1   last byte of frame
// - stat_sent        out  16  frames completed, wraps 0xffff->0
// - stat_dropped     out  16  requests dropped for bad opcode, wraps
// BEHAVIOUR
// - Reset: all outputs 0, state S_IDLE; takes effect next edge, also mid-frame (tvalid drops without
//   tlast; partial frame abandoned, downstream must tolerate).
// - Frame layout (bytes): 0-5 DA | 6-11 SA | 12-13 0x0806 | 14-15 HTYPE 0x0001 | 16-17 PTYPE 0x0800
//   | 18 HLEN 6 | 19 PLEN 4 | 20-21 OPER | 22-27 SHA | 28-31 SPA | 32-37 THA | 38-41 TPA
//   | 42-59 0x00 pad (PAD_TO_MIN=1). THA = dst_mac for REPLY, 0 for REQUEST.
// - States: S_IDLE, S_SEND, S_ACK, S_HOLDOFF.
// - S_IDLE: req=1 & valid opcode at edge N -> load frame shift register, cnt=0, ->S_SEND;
//   cycle N+1: tvalid=1, tdata=byte 0; ACK_ON_LAST=0: arp_tx_ack=1 in N+1 only.
//   req=1 & invalid opcode -> stat_dropped++, ->S_ACK (no tvalid).
// - S_SEND: on tvalid&tready shift 8 bits, cnt++; tdata/tlast stable while tvalid&!tready.
//   tlast=1 exactly when cnt==LEN-1 (LEN=60 or 42). Last handshake: stat_sent++,
//   ->S_ACK if ACK_ON_LAST=1 else ->S_IDLE (tvalid low next cycle).
// - S_ACK: ack=1 one cycle -> S_HOLDOFF. S_HOLDOFF: ignore req one cycle -> S_IDLE
//   (requester needs one cycle to drop req after ack; prevents double capture).
// - Inputs sampled only at capture; changes during S_SEND do not affect the frame in flight.
// - Max one frame in flight; req during S_SEND/S_ACK/S_HOLDOFF waits (not lost, level-held).
// - Throughput: with tready=1, LEN beats; next frame tvalid <=1 cycle after IDLE re-entry
//   (ACK_ON_LAST=0) or <=3 cycles after last beat (ACK_ON_LAST=1).
// - cnt 6 bits; stat counters modulo 2^16.
// STRUCTURE
// - axi_udp_pkg: ETHERTYPE_ARP=16'h0806, ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN/PLEN,
//   ARP_FRAME_LEN=42, ETH_MIN_LEN=60, existing ARP_OPER_*, BROADCAST_MAC; state_t enum.
// - Single module, reg_t record + comb/ff two-process; 480-bit frame shift register. No sub-module.
// TESTING (MAC 01:02:03:04:05:06, IP c0a80602)
// - Gratuitous: opcode 2, dst ff:ff:ff:ff:ff:ff/c0a80602 -> ff x6,010203040506,0806,0001 0800 06 04
//   0002, SHA, c0a80602, ff x6, c0a80602, 18x00; tlast on byte 59; one ack pulse; stat_sent=1.
// - Request: opcode 1, dst_ip c0a80601 -> DA ff x6, OPER 0001, THA 000000000000, TPA c0a80601.
// - Backpressure: tready random 50% -> byte stream identical to tready=1; tdata/tlast stable in stalls.
// - Bad opcode 0 with req -> ack within 2 cycles, tvalid never 1, stat_dropped=1, then IDLE.
// - Reset at byte 20 -> tvalid=0 next cycle, counters 0; next req yields complete 60-byte frame.
// - Back-to-back, both ACK_ON_LAST values, req re-raised 1 cycle after ack -> exactly 2 frames, 2 acks.

Source files
------------

// File: rtl/axi_udp_pkg.sv
// Shared constants and helpers for the Ethernet/ARP transmit path.
package axi_udp_pkg;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'd6;
    localparam logic [7:0]  ARP_PLEN         = 8'd4;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
    localparam logic [47:0] BROADCAST_MAC    = 48'hffff_ffff_ffff;

    localparam int ARP_FRAME_LEN = 42;
    localparam int ETH_MIN_LEN   = 60;
    localparam int FRAME_BITS    = ETH_MIN_LEN * 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_ACK,
        S_HOLDOFF
    } state_t;

    // Whole frame, byte 0 in the top bits, zero pad already in place.
    function automatic logic [FRAME_BITS-1:0] arp_build_frame(
        input logic [15:0] oper,
        input logic [47:0] src_mac,
        input logic [31:0] src_ip,
        input logic [47:0] dst_mac,
        input logic [31:0] dst_ip
    );
        logic [47:0] tha;
        tha = (oper == ARP_OPER_REPLY) ? dst_mac : 48'h0;
        return {dst_mac, src_mac, ETHERTYPE_ARP,
                ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, oper,
                src_mac, src_ip, tha, dst_ip,
                {(FRAME_BITS - ARP_FRAME_LEN * 8){1'b0}}};
    endfunction

endpackage

// File: rtl/axi_arp_tx.sv
// ARP transmitter: captures one request from the ARP state machine and
// serialises a single Ethernet II + ARP frame onto an 8-bit AXI4-Stream master.
module axi_arp_tx
    import axi_udp_pkg::*;
#(
    parameter bit PAD_TO_MIN  = 1'b1,
    parameter bit ACK_ON_LAST = 1'b0
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        arp_tx_req,
    output logic        arp_tx_ack,
    input  logic [15:0] arp_tx_opcode,
    input  logic [47:0] arp_tx_src_mac,
    input  logic [31:0] arp_tx_src_ip,
    input  logic [47:0] arp_tx_dst_mac,
    input  logic [31:0] arp_tx_dst_ip,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] stat_sent,
    output logic [15:0] stat_dropped
);

    localparam int         LEN      = PAD_TO_MIN ? ETH_MIN_LEN : ARP_FRAME_LEN;
    localparam logic [5:0] LAST_CNT = 6'(LEN - 1);

    typedef struct packed {
        state_t                  state;
        logic [FRAME_BITS-1:0]   frame;
        logic [5:0]              cnt;
        logic                    ack;
        logic [15:0]             sent;
        logic [15:0]             dropped;
    } reg_t;

    reg_t r_q, r_d;
    logic opcode_ok;
    logic beat;
    logic last_beat;

    always_comb begin
        // NOTE: every field gets its default before the case so no path can
        // leave a combinational output unassigned and infer a latch.
        r_d       = r_q;
        r_d.ack   = 1'b0;
        opcode_ok = (arp_tx_opcode == ARP_OPER_REQUEST) ||
                    (arp_tx_opcode == ARP_OPER_REPLY);
        beat      = (r_q.state == S_SEND) && m_axis_tready;
        last_beat = beat && (r_q.cnt == LAST_CNT);

        case (r_q.state)
            S_IDLE: begin
                if (arp_tx_req) begin
                    if (opcode_ok) begin
                        r_d.frame = arp_build_frame(arp_tx_opcode, arp_tx_src_mac,
                                                    arp_tx_src_ip, arp_tx_dst_mac,
                                                    arp_tx_dst_ip);
                        r_d.cnt   = 6'd0;
                        r_d.state = S_SEND;
                        r_d.ack   = !ACK_ON_LAST;
                    end else begin
                        r_d.dropped = r_q.dropped + 16'd1;
                        r_d.state   = S_ACK;
                        r_d.ack     = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (beat) begin
                    r_d.frame = {r_q.frame[FRAME_BITS-9:0], 8'h00};
                    r_d.cnt   = r_q.cnt + 6'd1;
                end
                if (last_beat) begin
                    r_d.sent = r_q.sent + 16'd1;
                    if (ACK_ON_LAST) begin
                        r_d.state = S_ACK;
                        r_d.ack   = 1'b1;
                    end else begin
                        r_d.state = S_IDLE;
                    end
                end
            end
            // Ack is registered, so it is high for the whole S_ACK cycle.
            S_ACK:     r_d.state = S_HOLDOFF;
            // Gives the requester a cycle to drop req so it is not captured twice.
            S_HOLDOFF: r_d.state = S_IDLE;
            default:   r_d.state = S_IDLE;
        endcase
    end

    // NOTE: the frame register is reset along with the control state so that
    // tdata reads 0 after reset; a mid-frame reset simply abandons the frame.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign arp_tx_ack    = r_q.ack;
    assign m_axis_tvalid = (r_q.state == S_SEND);
    assign m_axis_tdata  = r_q.frame[FRAME_BITS-1 -: 8];
    assign m_axis_tlast  = (r_q.state == S_SEND) && (r_q.cnt == LAST_CNT);
    assign stat_sent     = r_q.sent;
    assign stat_dropped  = r_q.dropped;

endmodule

// File: tb/tb_axi_arp_tx.sv
// Directed bench for axi_arp_tx: a padded/early-ack instance and an
// unpadded/late-ack instance share data inputs; 'sel' picks the one under test.
module tb_axi_arp_tx;

    // Hand-assembled 42-byte ARP frames (MAC 01:02:03:04:05:06, IP c0a80602).
    localparam logic [335:0] GRAT_FRAME =
        336'hffffffffffff_010203040506_0806_0001_0800_06_04_0002_010203040506_c0a80602_ffffffffffff_c0a80602;
    localparam logic [335:0] REQ_FRAME =
        336'hffffffffffff_010203040506_0806_0001_0800_06_04_0001_010203040506_c0a80602_000000000000_c0a80601;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        req;
    logic        sel;
    logic        ready;
    logic [15:0] opcode;
    logic [47:0] src_mac, dst_mac;
    logic [31:0] src_ip, dst_ip;

    logic        req0, req1;
    logic        ack0, ack1, valid0, valid1, last0, last1;
    logic [7:0]  data0, data1;
    logic [15:0] sent0, sent1, drop0, drop1;

    logic        o_ack, o_valid, o_last;
    logic [7:0]  o_data;
    logic [15:0] o_sent, o_drop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign req0    = req & ~sel;
    assign req1    = req & sel;
    assign o_ack   = sel ? ack1   : ack0;
    assign o_valid = sel ? valid1 : valid0;
    assign o_last  = sel ? last1  : last0;
    assign o_data  = sel ? data1  : data0;
    assign o_sent  = sel ? sent1  : sent0;
    assign o_drop  = sel ? drop1  : drop0;

    axi_arp_tx #(.PAD_TO_MIN(1'b1), .ACK_ON_LAST(1'b0)) dut0 (
        .clk(clk), .aresetn(aresetn),
        .arp_tx_req(req0), .arp_tx_ack(ack0), .arp_tx_opcode(opcode),
        .arp_tx_src_mac(src_mac), .arp_tx_src_ip(src_ip),
        .arp_tx_dst_mac(dst_mac), .arp_tx_dst_ip(dst_ip),
        .m_axis_tdata(data0), .m_axis_tvalid(valid0), .m_axis_tready(ready),
        .m_axis_tlast(last0), .stat_sent(sent0), .stat_dropped(drop0)
    );

    axi_arp_tx #(.PAD_TO_MIN(1'b0), .ACK_ON_LAST(1'b1)) dut1 (
        .clk(clk), .aresetn(aresetn),
        .arp_tx_req(req1), .arp_tx_ack(ack1), .arp_tx_opcode(opcode),
        .arp_tx_src_mac(src_mac), .arp_tx_src_ip(src_ip),
        .arp_tx_dst_mac(dst_mac), .arp_tx_dst_ip(dst_ip),
        .m_axis_tdata(data1), .m_axis_tvalid(valid1), .m_axis_tready(ready),
        .m_axis_tlast(last1), .stat_sent(sent1), .stat_dropped(drop1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request, collect the frame, compare every byte plus framing/ack timing.
    task automatic run_frame(input string name, input logic [15:0] op, input logic [47:0] dmac,
                             input logic [31:0] dip, input logic [335:0] exp42, input bit rnd);
        logic [7:0] got[$];
        logic [7:0] exp_b, got_b, prev_data;
        logic       prev_last;
        bit         done, prev_stall;
        int         len, tlast_idx, acks, first_valid, ack_cyc, last_cyc;
        int         cyc, post, stall_bad, extra_valid;
        len = sel ? 42 : 60;
        done = 0; prev_stall = 0; prev_data = 8'h00; prev_last = 1'b0;
        tlast_idx = -1; acks = 0; first_valid = -1; ack_cyc = -1; last_cyc = -1;
        cyc = 0; post = 0; stall_bad = 0; extra_valid = 0;
        opcode = op; dst_mac = dmac; dst_ip = dip; ready = 1'b1; req = 1'b1;
        while (post < 4 && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
            if (o_ack) begin acks++; ack_cyc = cyc; req = 1'b0; end
            if (prev_stall && (o_valid !== 1'b1 || o_data !== prev_data || o_last !== prev_last))
                stall_bad++;
            if (done) begin
                post++;
                if (o_valid) extra_valid++;
            end else begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (o_valid && first_valid < 0) first_valid = cyc;
                prev_stall = o_valid && !ready;
                prev_data  = o_data;
                prev_last  = o_last;
                if (o_valid && ready) begin
                    got.push_back(o_data);
                    if (o_last || got.size() >= 80) begin
                        done = 1; last_cyc = cyc;
                        if (o_last) tlast_idx = got.size() - 1;
                    end
                end
            end
        end
        ready = 1'b1; req = 1'b0;
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_len"}, 64'(got.size()), 64'(len));
        for (int i = 0; i < len; i++) begin
            exp_b = (i < 42) ? exp42[335 - 8*i -: 8] : 8'h00;
            got_b = (i < got.size()) ? got[i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), 64'(got_b), 64'(exp_b));
        end
        check({name, "_tlast_pos"}, 64'(tlast_idx), 64'(len - 1));
        check({name, "_acks"}, 64'(acks), 64'd1);
        check({name, "_first_valid"}, 64'(first_valid), 64'd1);
        check({name, "_ack_cycle"}, 64'(ack_cyc), 64'(sel ? last_cyc + 1 : first_valid));
        check({name, "_valid_after_last"}, 64'(extra_valid), 64'd0);
        check({name, "_stall_stable"}, 64'(stall_bad), 64'd0);
    endtask

    task automatic bad_opcode();
        int acks, ack_cyc, valid_seen;
        acks = 0; ack_cyc = -1; valid_seen = 0;
        opcode = 16'h0000; req = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            if (o_ack) begin acks++; if (ack_cyc < 0) ack_cyc = cyc; req = 1'b0; end
            if (o_valid) valid_seen++;
        end
        req = 1'b0;
        check("bad_ack_within_2", 64'(ack_cyc >= 1 && ack_cyc <= 2), 64'd1);
        check("bad_acks", 64'(acks), 64'd1);
        check("bad_no_valid", 64'(valid_seen), 64'd0);
        check("bad_dropped", 64'(o_drop), 64'd1);
    endtask

    task automatic mid_reset();
        int nbytes, cyc;
        bit hit;
        nbytes = 0; cyc = 0; hit = 0;
        opcode = 16'd2; dst_mac = 48'hffff_ffff_ffff; dst_ip = 32'hc0a80602;
        ready = 1'b1; req = 1'b1;
        while (!hit && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (o_ack) req = 1'b0;
            if (o_valid) begin
                if (nbytes == 20) begin hit = 1; aresetn = 1'b0; end
                else nbytes++;
            end
        end
        req = 1'b0;
        @(posedge clk); #1;
        check("rst_reached_byte20", 64'(hit), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_sent", 64'(o_sent), 64'd0);
        check("rst_dropped", 64'(o_drop), 64'd0);
        aresetn = 1'b1;
    endtask

    // Two requests, the second raised one cycle after the first ack.
    task automatic back_to_back(input string name);
        int cyc, post, acks, frames, issued, gap;
        bit rearm;
        cyc = 0; post = 0; acks = 0; frames = 0; issued = 1; gap = 0; rearm = 0;
        opcode = 16'd2; dst_mac = 48'hffff_ffff_ffff; dst_ip = 32'hc0a80602;
        ready = 1'b1; req = 1'b1;
        while (post < 6 && cyc < 600) begin
            @(posedge clk); #1; cyc++;
            if (rearm) begin req = 1'b1; rearm = 0; end
            if (o_ack) begin
                acks++; req = 1'b0;
                if (issued < 2) begin issued++; rearm = 1; end
            end
            if (frames == 1 && !o_valid) gap++;
            if (o_valid && o_last) frames++;
            if (frames >= 2) post++;
        end
        req = 1'b0;
        check({name, "_frames"}, 64'(frames), 64'd2);
        check({name, "_acks"}, 64'(acks), 64'd2);
        check({name, "_gap"}, 64'(gap), sel ? 64'd3 : 64'd1);
    endtask

    initial begin
        aresetn = 1'b0; req = 1'b0; sel = 1'b0; ready = 1'b1;
        opcode = 16'h0; dst_mac = 48'h0; dst_ip = 32'h0;
        src_mac = 48'h0102_0304_0506; src_ip = 32'hc0a80602;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(valid0), 64'd0);
        check("reset_ack", 64'(ack0), 64'd0);
        check("reset_last", 64'(last0), 64'd0);
        check("reset_data", 64'(data0), 64'd0);
        check("reset_sent", 64'(sent0), 64'd0);
        check("reset_dropped", 64'(drop0), 64'd0);
        check("reset_valid_alt", 64'(valid1), 64'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        run_frame("grat", 16'd2, 48'hffff_ffff_ffff, 32'hc0a80602, GRAT_FRAME, 1'b0);
        check("grat_sent", 64'(o_sent), 64'd1);
        run_frame("req_bp", 16'd1, 48'hffff_ffff_ffff, 32'hc0a80601, REQ_FRAME, 1'b1);
        check("req_sent", 64'(o_sent), 64'd2);
        bad_opcode();
        check("bad_sent_unchanged", 64'(o_sent), 64'd2);
        mid_reset();
        run_frame("post_rst", 16'd2, 48'hffff_ffff_ffff, 32'hc0a80602, GRAT_FRAME, 1'b0);
        check("post_rst_sent", 64'(o_sent), 64'd1);
        back_to_back("b2b_early");
        check("b2b_early_sent", 64'(o_sent), 64'd3);

        sel = 1'b1;
        @(posedge clk); #1;
        run_frame("alt_req", 16'd1, 48'hffff_ffff_ffff, 32'hc0a80601, REQ_FRAME, 1'b1);
        check("alt_sent", 64'(o_sent), 64'd1);
        back_to_back("b2b_late");
        check("b2b_late_sent", 64'(o_sent), 64'd3);
        check("alt_dropped", 64'(o_drop), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
